// File: rtl/bus_arbiter_mux_pkg.sv
// Shared constants for the bus arbiter: source indices, arbiter state encoding
// and the default bus width.
package bus_arbiter_mux_pkg;

  localparam int DEFAULT_WIDTH = 32;

  localparam int SRC_R0  = 0,  SRC_R1  = 1,  SRC_R2  = 2,  SRC_R3  = 3;
  localparam int SRC_R4  = 4,  SRC_R5  = 5,  SRC_R6  = 6,  SRC_R7  = 7;
  localparam int SRC_R8  = 8,  SRC_R9  = 9,  SRC_R10 = 10, SRC_R11 = 11;
  localparam int SRC_R12 = 12, SRC_R13 = 13, SRC_R14 = 14, SRC_R15 = 15;
  localparam int SRC_HI     = 16;
  localparam int SRC_LO     = 17;
  localparam int SRC_ZHI    = 18;
  localparam int SRC_ZLO    = 19;
  localparam int SRC_PC     = 20;
  localparam int SRC_MDR    = 21;
  localparam int SRC_INPORT = 22;
  localparam int SRC_CSIGN  = 23;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/bus_arbiter_mux_pick.sv
// Combinational winner selection: top-down search in fixed-priority mode,
// rotated upward search starting after start_idx in round-robin mode.
module rr_priority_pick #(
  parameter int NUM_SRC = 24,
  parameter int IDX_W   = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IDX_W-1:0]   start_idx,
  input  logic               mode,
  output logic [IDX_W-1:0]   win_idx,
  output logic               any_vld,
  output logic               multi
);

  always_comb begin
    win_idx = '0;
    any_vld = |req;
    multi   = ($countones(req) > 1);
    if (!mode) begin
      // Ascending scan; the last hit is the highest set index.
      for (int i = 0; i < NUM_SRC; i++) begin
        if (req[i]) win_idx = IDX_W'(i);
      end
    end else begin
      // Scan the rotation backwards so the nearest index after start_idx wins.
      for (int k = NUM_SRC; k >= 1; k--) begin
        if (req[(int'(start_idx) + k) % NUM_SRC]) begin
          win_idx = IDX_W'((int'(start_idx) + k) % NUM_SRC);
        end
      end
    end
  end

endmodule

// File: rtl/bus_arbiter_mux.sv
// Registered shared-bus arbiter and multiplexer with fixed-priority or
// round-robin selection and an owner lock for multi-cycle transfers.
module bus_arbiter_mux
  import bus_arbiter_mux_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int NUM_SRC = 24,
  parameter int IDX_W   = $clog2(NUM_SRC)
) (
  input  logic                     clock,
  input  logic                     clear_n,
  input  logic [NUM_SRC-1:0]       src_req,
  input  logic [NUM_SRC*WIDTH-1:0] src_data,
  input  logic                     mode,
  input  logic                     lock,
  output logic [WIDTH-1:0]         bus_out,
  output logic                     bus_valid,
  output logic [NUM_SRC-1:0]       grant,
  output logic [IDX_W-1:0]         grant_idx,
  output logic                     conflict,
  output logic                     locked
);

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0]   bus_out_q, bus_out_d;
  logic               bus_valid_q, bus_valid_d;
  logic [NUM_SRC-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;
  logic               conflict_q, conflict_d;

  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic               pick_multi;
  logic               hold;

  rr_priority_pick #(
    .NUM_SRC (NUM_SRC),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req       (src_req),
    .start_idx (rr_ptr_q),
    .mode      (mode),
    .win_idx   (pick_idx),
    .any_vld   (pick_any),
    .multi     (pick_multi)
  );

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    bus_out_d   = bus_out_q;
    bus_valid_d = bus_valid_q;
    grant_d     = grant_q;
    grant_idx_d = grant_idx_q;
    conflict_d  = conflict_q;
    hold        = (state_q == LOCKED) && lock && src_req[grant_idx_q];

    if (hold) begin
      // Locked owner keeps the bus; its word is refreshed every cycle.
      bus_out_d   = src_data[int'(grant_idx_q)*WIDTH +: WIDTH];
      bus_valid_d = 1'b1;
      conflict_d  = 1'b0;
    end else if (!pick_any) begin
      state_d     = ARB;
      bus_valid_d = 1'b0;
      grant_d     = '0;
      conflict_d  = 1'b0;
    end else begin
      bus_out_d          = src_data[int'(pick_idx)*WIDTH +: WIDTH];
      grant_d            = '0;
      grant_d[pick_idx]  = 1'b1;
      grant_idx_d        = pick_idx;
      bus_valid_d        = 1'b1;
      conflict_d         = pick_multi;
      rr_ptr_d           = pick_idx;
      state_d            = lock ? LOCKED : ARB;
    end
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q     <= ARB;
      rr_ptr_q    <= IDX_W'(NUM_SRC-1);
      bus_out_q   <= '0;
      bus_valid_q <= 1'b0;
      grant_q     <= '0;
      grant_idx_q <= '0;
      conflict_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      bus_out_q   <= bus_out_d;
      bus_valid_q <= bus_valid_d;
      grant_q     <= grant_d;
      grant_idx_q <= grant_idx_d;
      conflict_q  <= conflict_d;
    end
  end

  assign bus_out   = bus_out_q;
  assign bus_valid = bus_valid_q;
  assign grant     = grant_q;
  assign grant_idx = grant_idx_q;
  assign conflict  = conflict_q;
  assign locked    = (state_q == LOCKED);

endmodule

// File: tb/tb_bus_arbiter_mux.sv
// Randomized and directed bench for bus_arbiter_mux, checked cycle by cycle
// against a behavioural model of the arbitration rules.
module tb_bus_arbiter_mux;
  import bus_arbiter_mux_pkg::*;

  localparam int WIDTH   = 32;
  localparam int NUM_SRC = 24;
  localparam int IDX_W   = $clog2(NUM_SRC);

  logic                     clock = 1'b0;
  logic                     clear_n = 1'b0;
  logic [NUM_SRC-1:0]       src_req = '0;
  logic [NUM_SRC*WIDTH-1:0] src_data = '0;
  logic                     mode = 1'b0;
  logic                     lock = 1'b0;
  logic [WIDTH-1:0]         bus_out;
  logic                     bus_valid;
  logic [NUM_SRC-1:0]       grant;
  logic [IDX_W-1:0]         grant_idx;
  logic                     conflict;
  logic                     locked;

  bus_arbiter_mux #(.WIDTH(WIDTH), .NUM_SRC(NUM_SRC)) dut (
    .clock     (clock),
    .clear_n   (clear_n),
    .src_req   (src_req),
    .src_data  (src_data),
    .mode      (mode),
    .lock      (lock),
    .bus_out   (bus_out),
    .bus_valid (bus_valid),
    .grant     (grant),
    .grant_idx (grant_idx),
    .conflict  (conflict),
    .locked    (locked)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  logic [WIDTH-1:0] data_arr [NUM_SRC];

  // Reference model state
  bit               m_locked;
  int               m_rr;
  int               m_idx;
  logic [WIDTH-1:0] m_bus;
  bit               m_vld;
  logic [NUM_SRC-1:0] m_grant;
  bit               m_conf;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_locked = 0; m_rr = NUM_SRC-1; m_idx = 0; m_bus = '0;
    m_vld = 0; m_grant = '0; m_conf = 0;
  endtask

  task automatic model_step();
    int cnt, w;
    if (m_locked && lock && src_req[m_idx]) begin
      m_bus = data_arr[m_idx]; m_vld = 1; m_conf = 0;
    end else begin
      cnt = 0;
      for (int i = 0; i < NUM_SRC; i++) cnt += int'(src_req[i]);
      if (cnt == 0) begin
        m_vld = 0; m_grant = '0; m_conf = 0; m_locked = 0;
      end else begin
        w = -1;
        if (!mode) begin
          for (int i = NUM_SRC-1; i >= 0 && w < 0; i--) if (src_req[i]) w = i;
        end else begin
          for (int k = 1; k <= NUM_SRC && w < 0; k++)
            if (src_req[(m_rr + k) % NUM_SRC]) w = (m_rr + k) % NUM_SRC;
        end
        m_bus = data_arr[w]; m_grant = '0; m_grant[w] = 1'b1; m_idx = w;
        m_vld = 1; m_conf = (cnt > 1); m_rr = w; m_locked = lock;
      end
    end
  endtask

  task automatic check_all();
    chk("bus_out",   64'(bus_out),   64'(m_bus));
    chk("bus_valid", 64'(bus_valid), 64'(m_vld));
    chk("grant",     64'(grant),     64'(m_grant));
    chk("grant_idx", 64'(grant_idx), 64'(m_idx));
    chk("conflict",  64'(conflict),  64'(m_conf));
    chk("locked",    64'(locked),    64'(m_locked));
  endtask

  // Apply inputs at the falling edge, advance the model, check after the rising edge.
  task automatic cyc(input logic [NUM_SRC-1:0] req, input logic md, input logic lk);
    @(negedge clock);
    src_req = req; mode = md; lock = lk;
    for (int i = 0; i < NUM_SRC; i++) src_data[i*WIDTH +: WIDTH] = data_arr[i];
    model_step();
    @(posedge clock);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    @(negedge clock);
    clear_n = 0; src_req = '0; lock = 0;
    #1;
    model_reset();
    check_all();
    @(negedge clock);
    clear_n = 1;
  endtask

  logic [NUM_SRC-1:0] r;

  initial begin
    for (int i = 0; i < NUM_SRC; i++) data_arr[i] = 32'h1000_0000 + i;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check_all();
    @(negedge clock);
    clear_n = 1;

    // Fixed priority, two requesters
    data_arr[SRC_MDR] = 32'hDEADBEEF;
    cyc((24'd1 << 3) | (24'd1 << SRC_MDR), 0, 0);
    chk("t1_idx", 64'(grant_idx), 64'd21);
    chk("t1_bus", 64'(bus_out), 64'hDEADBEEF);

    // Round-robin rotation from reset pointer
    do_reset();
    r = (24'd1 << 2) | (24'd1 << 5) | (24'd1 << 9);
    cyc(r, 1, 0); chk("t2_a", 64'(grant_idx), 64'd2);
    cyc(r, 1, 0); chk("t2_b", 64'(grant_idx), 64'd5);
    cyc(r, 1, 0); chk("t2_c", 64'(grant_idx), 64'd9);
    cyc(r, 1, 0); chk("t2_d", 64'(grant_idx), 64'd2);

    // Wrap-around from pointer 23
    cyc(24'd1 << SRC_CSIGN, 0, 0);
    cyc((24'd1 << SRC_CSIGN) | 24'd1, 1, 0);
    chk("t3_wrap", 64'(grant_idx), 64'd0);

    // Lock with competing request, then release
    data_arr[4] = 32'h1; cyc(24'd1 << 4, 0, 1);
    chk("t4_lk", 64'(locked), 64'd1);
    r = (24'd1 << 4) | (24'd1 << SRC_PC);
    data_arr[4] = 32'h2; cyc(r, 0, 1);
    chk("t4_b2", 64'(bus_out), 64'h2);
    data_arr[4] = 32'h3; cyc(r, 0, 1);
    chk("t4_b3", 64'(bus_out), 64'h3);
    chk("t4_own", 64'(grant_idx), 64'd4);
    cyc(r, 0, 0);
    chk("t4_rel", 64'(grant_idx), 64'd20);

    // Locked owner drops its request
    cyc(24'd1 << 7, 0, 1);
    cyc(24'd0, 0, 1);
    chk("t5_vld", 64'(bus_valid), 64'd0);
    chk("t5_bus", 64'(bus_out), 64'(data_arr[7]));

    // Asynchronous reset mid-lock
    cyc(24'd1 << 9, 0, 1);
    cyc(24'd1 << 9, 0, 1);
    #2;
    clear_n = 0;
    #1;
    model_reset();
    check_all();
    @(negedge clock);
    clear_n = 1;
    cyc(24'd3, 1, 0);
    chk("t6_first", 64'(grant_idx), 64'd0);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NUM_SRC; i++) data_arr[i] = $urandom;
      r = NUM_SRC'($urandom & $urandom);
      if ($urandom_range(0, 7) == 0) r = '0;
      cyc(r, 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
